monolith_bars_pipe: RTL and testbench

MONOLITH_BARS_PIPE -- requirements
Module: monolith_bars_pipe

---
 rtl/monolith_pkg.sv | 31 +++
 rtl/monolith_bar.sv | 27 ++
 rtl/monolith_sbox.sv | 33 +++
 rtl/monolith_bars_pipe.sv | 121 ++++++++++++
 tb/tb_monolith_bars_pipe.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/monolith_pkg.sv
// Shared definitions for the Monolith permutation datapath.
//   M31_WIDTH / M31_P   : Mersenne-31 element width and modulus
//   LIMBn_W             : Bars limb widths, low to high (8, 8, 8, 7)
//   m31_t               : one field element
//   bar_limbs_t         : packed element split into its four Bars limbs;
//                         its bit layout is identical to m31_t
package monolith_pkg;

  localparam int unsigned M31_WIDTH = 31;
  localparam logic [M31_WIDTH-1:0] M31_P = 31'h7FFFFFFF;

  localparam int unsigned LIMB0_W = 8;
  localparam int unsigned LIMB1_W = 8;
  localparam int unsigned LIMB2_W = 8;
  localparam int unsigned LIMB3_W = 7;

  typedef logic [M31_WIDTH-1:0] m31_t;

  typedef struct packed {
    logic [LIMB3_W-1:0] l3;
    logic [LIMB2_W-1:0] l2;
    logic [LIMB1_W-1:0] l1;
    logic [LIMB0_W-1:0] l0;
  } bar_limbs_t;

  // The only 31-bit pattern that is not a canonical field element is p itself.
  function automatic logic m31_out_of_field(input m31_t x);
    return x >= M31_P;
  endfunction

endpackage

// File: rtl/monolith_bar.sv
// Bars map for one M31 element (combinational): splits x into limbs
// L0=x[7:0], L1=x[15:8], L2=x[23:16], L3=x[30:24] and S-boxes each limb.
// Ports: x (element in), y (S-boxed limbs; recomposing is a plain
// concatenation, no modular reduction).
module monolith_bar
  import monolith_pkg::*;
(
  input  m31_t       x,
  output bar_limbs_t y
);

  bar_limbs_t limbs;
  logic [LIMB0_W-1:0] s0;
  logic [LIMB1_W-1:0] s1;
  logic [LIMB2_W-1:0] s2;
  logic [LIMB3_W-1:0] s3;

  assign limbs = bar_limbs_t'(x);

  monolith_sbox #(.WIDTH(LIMB0_W)) u_sbox0 (.v(limbs.l0), .s(s0));
  monolith_sbox #(.WIDTH(LIMB1_W)) u_sbox1 (.v(limbs.l1), .s(s1));
  monolith_sbox #(.WIDTH(LIMB2_W)) u_sbox2 (.v(limbs.l2), .s(s2));
  monolith_sbox #(.WIDTH(LIMB3_W)) u_sbox3 (.v(limbs.l3), .s(s3));

  assign y = {s3, s2, s1, s0};

endmodule

// File: rtl/monolith_sbox.sv
// Monolith Bars S-box on one limb (combinational).
//   WIDTH = 8 : s = rotl1(v ^ (rotl1(~v) & rotl2(v) & rotl3(v)))
//   WIDTH = 7 : s = rotl1(v ^ (rotl1(~v) & rotl2(v)))
// Ports: v (limb in), s (limb out). All rotations stay within WIDTH bits.
module monolith_sbox #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH-1:0] nv_r1;
  logic [WIDTH-1:0] v_r2;
  logic [WIDTH-1:0] mix;
  logic [WIDTH-1:0] t;

  assign nv_r1 = {~v[WIDTH-2:0], ~v[WIDTH-1]};
  assign v_r2  = {v[WIDTH-3:0], v[WIDTH-1:WIDTH-2]};

  if (WIDTH == 8) begin : g_w8
    logic [WIDTH-1:0] v_r3;
    assign v_r3 = {v[WIDTH-4:0], v[WIDTH-1:WIDTH-3]};
    assign mix  = nv_r1 & v_r2 & v_r3;
  end else if (WIDTH == 7) begin : g_w7
    assign mix = nv_r1 & v_r2;
  end else begin : g_bad
    $error("monolith_sbox: WIDTH must be 7 or 8");
  end

  assign t = v ^ mix;
  assign s = {t[WIDTH-2:0], t[WIDTH-1]};

endmodule

// File: rtl/monolith_bars_pipe.sv
// Monolith Bars layer as a 2-stage valid/ready pipeline.
// Elements 0..BARS_LANES-1 go through the Bars map; the remaining elements
// pass through with the same 2-cycle latency.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   : input handshake, in_data = STATE_WIDTH x 31 bits,
//                         element i at [31*i+30:31*i]
//   out_valid/out_ready : output handshake, out_data packed like in_data
//   range_err           : sticky flag, set when an accepted Bars-lane element
//                         equals p; only present with
//                         MONOLITH_BARS_RANGE_CHECK_EN defined
module monolith_bars_pipe
  import monolith_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = 16,
  parameter int unsigned BARS_LANES  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [STATE_WIDTH*M31_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [STATE_WIDTH*M31_WIDTH-1:0] out_data
`ifdef MONOLITH_BARS_RANGE_CHECK_EN
  ,
  output logic                             range_err
`endif
);

  localparam int unsigned DW = STATE_WIDTH * M31_WIDTH;

  if (BARS_LANES < 1 || BARS_LANES > STATE_WIDTH) begin : g_bad_lanes
    $error("monolith_bars_pipe: BARS_LANES must be in 1..STATE_WIDTH");
  end

  bar_limbs_t        lane_next [STATE_WIDTH];
  bar_limbs_t        s1_lane   [STATE_WIDTH];
  logic              s1_valid;
  logic              s2_load;
  logic              in_fire;
  logic [DW-1:0]     out_next;

  // Pass-through lanes ride in the same limb-struct register as Bars lanes,
  // so both see identical latency and recomposition.
  for (genvar i = 0; i < STATE_WIDTH; i++) begin : g_lane
    if (i < BARS_LANES) begin : g_bar
      monolith_bar u_bar (
        .x(in_data[M31_WIDTH*i +: M31_WIDTH]),
        .y(lane_next[i])
      );
    end else begin : g_pass
      assign lane_next[i] = bar_limbs_t'(in_data[M31_WIDTH*i +: M31_WIDTH]);
    end
  end

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      for (int unsigned i = 0; i < STATE_WIDTH; i++) begin
        s1_lane[i] <= '0;
      end
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        for (int unsigned i = 0; i < STATE_WIDTH; i++) begin
          s1_lane[i] <= lane_next[i];
        end
      end
    end
  end

  always_comb begin
    out_next = '0;
    for (int unsigned i = 0; i < STATE_WIDTH; i++) begin
      out_next[M31_WIDTH*i +: M31_WIDTH] =
        {s1_lane[i].l3, s1_lane[i].l2, s1_lane[i].l1, s1_lane[i].l0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= out_next;
      end
    end
  end

`ifdef MONOLITH_BARS_RANGE_CHECK_EN
  logic over_p;

  always_comb begin
    over_p = 1'b0;
    for (int unsigned i = 0; i < BARS_LANES; i++) begin
      if (m31_out_of_field(in_data[M31_WIDTH*i +: M31_WIDTH])) begin
        over_p = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (in_fire && over_p) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_monolith_bars_pipe.sv
module tb_monolith_bars_pipe;

  localparam int SW = 16;
  localparam int BL = 8;
  localparam int W  = SW * 31;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef MONOLITH_BARS_RANGE_CHECK_EN
  logic         range_err;
`endif

  always #5 clk = ~clk;

  monolith_bars_pipe #(.STATE_WIDTH(SW), .BARS_LANES(BL)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef MONOLITH_BARS_RANGE_CHECK_EN
    ,
    .range_err(range_err)
`endif
  );

  typedef struct {
    logic [30:0] a;   // applied to Bars lanes 0 and BL-1
    logic [30:0] ea;  // hand-computed Bars result
    logic [30:0] p;   // applied to pass lanes BL and SW-1
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] q[$];
  int n_in, n_out, cyc_n, out_first, out_last;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference Bars S-boxes written bitwise: t[j] = v[j] ^ (~v[j-1] & v[j-2] (& v[j-3])),
  // s[j] = t[j-1], indices modulo the limb width.
  function automatic logic [7:0] ref_s8(input logic [7:0] v);
    logic [7:0] t, r;
    for (int j = 0; j < 8; j++) t[j] = v[j] ^ (~v[(j+7)%8] & v[(j+6)%8] & v[(j+5)%8]);
    for (int j = 0; j < 8; j++) r[j] = t[(j+7)%8];
    return r;
  endfunction

  function automatic logic [6:0] ref_s7(input logic [6:0] v);
    logic [6:0] t, r;
    for (int j = 0; j < 7; j++) t[j] = v[j] ^ (~v[(j+6)%7] & v[(j+5)%7]);
    for (int j = 0; j < 7; j++) r[j] = t[(j+6)%7];
    return r;
  endfunction

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] d);
    logic [W-1:0] r;
    logic [30:0]  e;
    for (int i = 0; i < SW; i++) begin
      e = d[31*i +: 31];
      if (i < BL) e = {ref_s7(e[30:24]), ref_s8(e[23:16]), ref_s8(e[15:8]), ref_s8(e[7:0])};
      r[31*i +: 31] = e;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    logic [30:0]  e;
    for (int i = 0; i < SW; i++) begin
      e = 31'($urandom);
      if (i < BL && e == 31'h7FFFFFFF) e = '0;
      w[31*i +: 31] = e;
    end
    return w;
  endfunction

  function automatic logic [W-1:0] mk(input logic [30:0] a, input logic [30:0] p);
    logic [W-1:0] w;
    w = '0;
    w[0 +: 31]        = a;
    w[31*(BL-1) +: 31] = a;
    w[31*BL +: 31]     = p;
    w[31*(SW-1) +: 31] = p;
    return w;
  endfunction

  // One clock: handshakes are observed mid-cycle, then return 1 time unit after the edge.
  task automatic cyc();
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected output: got %0h expected none", out_data);
      end else begin
        chk("stream data", out_data, q.pop_front());
      end
      n_out++;
      if (out_first < 0) out_first = cyc_n;
      out_last = cyc_n;
    end
    if (in_valid && in_ready === 1'b1) begin
      q.push_back(ref_word(in_data));
      n_in++;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[7];

  initial begin
    int base_in, base_out, k;
    logic [W-1:0] wa, wb, wc;

    vt[0] = '{31'h00000001, 31'h00000002, 31'h12345678};
    vt[1] = '{31'h7FFFFFFE, 31'h7FFFFFF9, 31'h7FFFFFFF};
    vt[2] = '{31'h00000000, 31'h00000000, 31'h00000001};
    vt[3] = '{31'h7F000000, 31'h7F000000, 31'h55555555};
    vt[4] = '{31'h000000FF, 31'h000000FF, 31'h2AAAAAAA};
    vt[5] = '{31'h00000080, 31'h00000001, 31'h00000080};
    vt[6] = '{31'h01060006, 31'h0A2C002C, 31'h01060006};

    n_in = 0; n_out = 0; cyc_n = 0; out_first = -1; out_last = -1;

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, '0);
    chk("reset out_data", out_data, '0);
`ifdef MONOLITH_BARS_RANGE_CHECK_EN
    chk("reset range_err", range_err, '0);
`endif
    rst = 1'b0;
    chk("in_ready after reset", in_ready, 1);

    // Directed vectors: exactly two edges from acceptance to out_valid
    for (int v = 0; v < 7; v++) begin
      in_valid = 1'b1;
      in_data  = mk(vt[v].a, vt[v].p);
      #1;
      chk("vec in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = rand_word();
      chk("vec out_valid after 1 edge", out_valid, '0);
      @(posedge clk); #1;
      chk("vec out_valid after 2 edges", out_valid, 1);
      chk("vec out_data", out_data, mk(vt[v].ea, vt[v].p));
      @(posedge clk); #1;
      chk("vec out_valid drops", out_valid, '0);
    end

    // Data without in_valid must not produce output
    for (int c = 0; c < 3; c++) begin
      in_data = rand_word();
      cyc();
      chk("idle no output", out_valid, '0);
    end

    // Back-to-back stream of 100 words
    base_in = n_in; base_out = n_out; out_first = -1; out_last = -1;
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = rand_word();
    for (int c = 0; c < 100; c++) begin
      k = n_in;
      cyc();
      if (n_in != k) in_data = rand_word();
    end
    chk("stream accepted in 100 cycles", n_in - base_in, 100);
    in_valid = 1'b0;
    for (int c = 0; c < 20 && (n_out - base_out) < 100; c++) cyc();
    chk("stream outputs", n_out - base_out, 100);
    chk("stream contiguous", out_last - out_first, 99);
    chk("stream queue empty", q.size(), '0);

    // Backpressure: out_ready low for 5 cycles with in_valid held high
    wa = rand_word(); wb = rand_word(); wc = rand_word();
    base_in = n_in; base_out = n_out;
    out_ready = 1'b0; in_valid = 1'b1; in_data = wa;
    for (int c = 0; c < 5; c++) begin
      k = n_in;
      cyc();
      if (n_in != k) in_data = (n_in - base_in == 1) ? wb : wc;
      if (c >= 1) begin
        chk("stall out_valid", out_valid, 1);
        chk("stall out_data stable", out_data, ref_word(wa));
      end
    end
    chk("stall accepted count", n_in - base_in, 2);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && (n_out - base_out) < 2; c++) cyc();
    chk("stall release outputs", n_out - base_out, 2);
    chk("stall queue empty", q.size(), '0);
    chk("stall drained", out_valid, '0);

    // Reset with two words in flight
    in_valid = 1'b1; in_data = rand_word();
    cyc();
    in_data = rand_word();
    cyc();
    in_valid = 1'b0;
    chk("pre-reset out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid-op reset out_valid", out_valid, '0);
    chk("mid-op reset out_data", out_data, '0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("in_ready after mid-op reset", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("no stale output", out_valid, '0);
    end
    in_valid = 1'b1; in_data = '0;
    cyc();
    in_valid = 1'b0;
    chk("post-reset latency 1", out_valid, '0);
    cyc();
    chk("post-reset latency 2", out_valid, 1);
    chk("post-reset zero word", out_data, '0);
    cyc();
    chk("post-reset queue empty", q.size(), '0);

`ifdef MONOLITH_BARS_RANGE_CHECK_EN
    in_valid = 1'b1;
    in_data  = '0;
    in_data[30:0] = 31'h7FFFFFFF;
    #1;
    chk("range_err before accept", range_err, '0);
    cyc();
    chk("range_err set", range_err, 1);
    in_data = rand_word();
    for (int c = 0; c < 10; c++) begin
      k = n_in;
      cyc();
      if (n_in != k) in_data = rand_word();
      chk("range_err sticky", range_err, 1);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && q.size() != 0; c++) cyc();
    chk("range queue empty", q.size(), '0);
    rst = 1'b1;
    #1;
    chk("range_err cleared", range_err, '0);
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
